// File: rtl/lfsr_encrypt_engine_if.sv
// Bus between the encrypt engine and its host: start/done handshake plus a
// single-port data memory with one-cycle read latency.
interface lfsr_encrypt_engine_if;
    logic       req;
    logic       ack;
    logic [7:0] mem_addr;
    logic [7:0] mem_rd_data;
    logic       mem_wr_en;
    logic [7:0] mem_wr_data;

    modport master (
        input  req,
        input  mem_rd_data,
        output ack,
        output mem_addr,
        output mem_wr_en,
        output mem_wr_data
    );

    modport slave (
        output req,
        output mem_rd_data,
        input  ack,
        input  mem_addr,
        input  mem_wr_en,
        input  mem_wr_data
    );
endinterface

// File: rtl/lfsr_encrypt_engine.sv
// Encrypts the padded plaintext in data memory with a 7-bit LFSR keystream and
// writes 64 ciphertext bytes to DM[OUT_BASE..OUT_BASE+63].
module lfsr_encrypt_engine #(
    parameter int MSG_MAX   = 61,
    parameter int OUT_BASE  = 64,
    parameter int CFG_BASE  = 61,
    parameter bit PARITY_EN = 1'b0
) (
    input  logic                  clk,
    input  logic                  init,
    lfsr_encrypt_engine_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_CFG0, S_CFG1, S_CFG2, S_CFG3, S_RD, S_WR, S_DONE
    } state_t;

    localparam logic [7:0] MSG_MAX_B  = 8'(MSG_MAX);
    localparam logic [7:0] OUT_BASE_B = 8'(OUT_BASE);
    localparam logic [7:0] CFG_BASE_B = 8'(CFG_BASE);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_req_q;
    logic [5:0]  r_pre;
    logic [6:0]  r_taps;
    logic [6:0]  r_lfsr;
    logic [5:0]  r_idx;

    logic [7:0]  w_k;
    logic        w_in_msg;
    logic [7:0]  w_ch;
    logic [7:0]  w_cipher;
    logic        w_fb;

    // Shift the printable range down to 0x00 and mask with the keystream;
    // the MSB carries odd parity over the 7 data bits when enabled.
    function automatic logic [7:0] encrypt_byte(input logic [7:0] ch, input logic [6:0] key);
        logic [7:0] diff;
        logic [6:0] enc;
        diff = ch - 8'h20;
        enc  = diff[6:0] ^ key;
        return {(PARITY_EN ? ~^enc : 1'b0), enc};
    endfunction

    assign w_k      = {2'b00, r_idx} - {2'b00, r_pre};
    assign w_in_msg = (r_idx >= r_pre) && (w_k < MSG_MAX_B);
    assign w_ch     = w_in_msg ? bus.mem_rd_data : 8'h20;
    assign w_cipher = encrypt_byte(w_ch, r_lfsr);
    assign w_fb     = ^(r_lfsr & r_taps);

    always_ff @(posedge clk) begin
        if (init) begin
            r_state <= S_IDLE;
            r_req_q <= 1'b0;
            r_lfsr  <= 7'h00;
            r_idx   <= 6'd0;
        end else begin
            r_state <= w_state_nxt;
            r_req_q <= bus.req;
            case (r_state)
                S_CFG1: r_pre  <= bus.mem_rd_data[5:0];
                S_CFG2: r_taps <= bus.mem_rd_data[6:0];
                S_CFG3: begin
                    // An all-zero seed would lock the LFSR, so it is promoted to 1.
                    r_lfsr <= (bus.mem_rd_data[6:0] == 7'h00) ? 7'h01 : bus.mem_rd_data[6:0];
                    r_idx  <= 6'd0;
                end
                S_WR: begin
                    r_lfsr <= {r_lfsr[5:0], w_fb};
                    r_idx  <= r_idx + 6'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        bus.ack         = 1'b0;
        bus.mem_addr    = 8'h00;
        bus.mem_wr_en   = 1'b0;
        bus.mem_wr_data = 8'h00;
        case (r_state)
            S_IDLE: if (r_req_q && !bus.req) w_state_nxt = S_CFG0;
            S_CFG0: begin
                bus.mem_addr = CFG_BASE_B;
                w_state_nxt  = S_CFG1;
            end
            S_CFG1: begin
                bus.mem_addr = CFG_BASE_B + 8'd1;
                w_state_nxt  = S_CFG2;
            end
            S_CFG2: begin
                bus.mem_addr = CFG_BASE_B + 8'd2;
                w_state_nxt  = S_CFG3;
            end
            S_CFG3: w_state_nxt = S_RD;
            S_RD: begin
                bus.mem_addr = w_in_msg ? w_k : 8'h00;
                w_state_nxt  = S_WR;
            end
            S_WR: begin
                bus.mem_addr    = OUT_BASE_B + {2'b00, r_idx};
                bus.mem_wr_en   = 1'b1;
                bus.mem_wr_data = w_cipher;
                w_state_nxt     = (r_idx == 6'd63) ? S_DONE : S_RD;
            end
            S_DONE: begin
                bus.ack = 1'b1;
                if (bus.req) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_lfsr_encrypt_engine.sv
// Scoreboard bench: expected ciphertext writes are queued when a run is issued
// and a monitor pops and compares them as the engine writes memory.
module tb_lfsr_encrypt_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic init;
    lfsr_encrypt_engine_if if0 ();
    lfsr_encrypt_engine_if if1 ();

    lfsr_encrypt_engine #(.PARITY_EN(1'b0)) dut0 (.clk(clk), .init(init), .bus(if0));
    lfsr_encrypt_engine #(.PARITY_EN(1'b1)) dut1 (.clk(clk), .init(init), .bus(if1));

    logic       sel;
    logic [7:0] dm [256];
    logic [7:0] rd_q;
    logic       bd_we;
    logic [7:0] bd_addr, bd_data;
    logic [7:0] msg [61];
    logic [7:0] snap [64];
    logic [7:0] q_addr [$];
    logic [7:0] q_data [$];
    int         n_cmp = 0;
    int         n_bad = 0;

    wire       w_wr_en = sel ? if1.mem_wr_en   : if0.mem_wr_en;
    wire [7:0] w_addr  = sel ? if1.mem_addr    : if0.mem_addr;
    wire [7:0] w_wdata = sel ? if1.mem_wr_data : if0.mem_wr_data;

    assign if0.mem_rd_data = rd_q;
    assign if1.mem_rd_data = rd_q;

    always @(posedge clk) begin
        if (bd_we) dm[bd_addr] <= bd_data;
        else if (w_wr_en) dm[w_addr] <= w_wdata;
        rd_q <= dm[w_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every DUT write must match the head of the expectation queue.
    initial begin
        logic [7:0] ea, ed;
        forever begin
            @(negedge clk);
            if (w_wr_en === 1'b1) begin
                if (q_addr.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_write: addr %0h data %0h, expected no write", w_addr, w_wdata);
                end else begin
                    ea = q_addr.pop_front();
                    ed = q_data.pop_front();
                    chk("wr_addr", {24'h0, w_addr}, {24'h0, ea});
                    chk("wr_data", {24'h0, w_wdata}, {24'h0, ed});
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic bd(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        @(posedge clk);
        #1 bd_we = 1'b0;
    endtask

    // mode 0: 'A' then a pattern including out-of-range bytes; 1: all spaces; 2: scrambled
    task automatic load(input int mode, input logic [7:0] pre, input logic [7:0] taps,
                        input logic [7:0] seed);
        for (int j = 0; j < 61; j++) begin
            case (mode)
                0: msg[j] = (j == 0) ? 8'h41 : 8'(32 + j * 3);
                1: msg[j] = 8'h20;
                default: msg[j] = 8'(j * 37 + 11);
            endcase
            bd(8'(j), msg[j]);
        end
        bd(8'd61, pre);
        bd(8'd62, taps);
        bd(8'd63, seed);
        for (int j = 64; j < 128; j++) bd(8'(j), 8'hEE);
    endtask

    task automatic push_exp(input int pre, input logic [6:0] taps, input logic [6:0] seed,
                            input bit par);
        logic [6:0] l;
        logic [7:0] ch, d;
        logic [6:0] e;
        int k;
        l = (seed == 7'h00) ? 7'h01 : seed;
        for (int i = 0; i < 64; i++) begin
            k  = i - pre;
            ch = (i >= pre && k < 61) ? msg[k] : 8'h20;
            d  = ch - 8'h20;
            e  = d[6:0] ^ l;
            q_addr.push_back(8'(64 + i));
            q_data.push_back({(par ? ~^e : 1'b0), e});
            l  = {l[5:0], ^(l & taps)};
        end
    endtask

    task automatic set_req(input bit s, input logic v);
        if (s) if1.req = v; else if0.req = v;
    endtask

    // Pulse req high then low; count cycles from the edge that samples the fall.
    task automatic run(input bit s, input bit glitch, output int cyc);
        logic a;
        @(negedge clk);
        sel = s;
        set_req(s, 1'b1);
        @(negedge clk);
        set_req(s, 1'b0);
        cyc = 0;
        a = 1'b0;
        while (cyc < 300 && !a) begin
            @(posedge clk);
            cyc++;
            #1;
            if (glitch && cyc == 40) set_req(s, 1'b1);
            if (glitch && cyc == 41) set_req(s, 1'b0);
            a = s ? if1.ack : if0.ack;
        end
        chk("ack_latency", cyc, 133);
        chk("queue_drained", q_addr.size(), 0);
    endtask

    initial begin
        int cyc, nd;
        bit found;
        init = 1'b1; sel = 1'b0; bd_we = 1'b0; bd_addr = 8'h00; bd_data = 8'h00;
        if0.req = 1'b0; if1.req = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ack",     {31'h0, if0.ack}, 0);
        chk("rst_wr_en",   {31'h0, if0.mem_wr_en}, 0);
        chk("rst_addr",    {24'h0, if0.mem_addr}, 0);
        chk("rst_wr_data", {24'h0, if0.mem_wr_data}, 0);
        chk("rst_ack_par", {31'h0, if1.ack}, 0);
        init = 1'b0;
        repeat (20) @(negedge clk);
        chk("no_start_low_req", {31'h0, if0.ack}, 0);

        // Case 1: taps 0x5C, seed 0x01, pre 10, message starts with 'A'
        load(0, 8'd10, 8'h5C, 8'h01);
        push_exp(10, 7'h5C, 7'h01, 1'b0);
        run(1'b0, 1'b0, cyc);
        chk("c1_out0",  {24'h0, dm[64]}, 32'h01);
        chk("c1_out1",  {24'h0, dm[65]}, 32'h02);
        chk("c1_out2",  {24'h0, dm[66]}, 32'h04);
        chk("c1_out3",  {24'h0, dm[67]}, 32'h09);
        chk("c1_out9",  {24'h0, dm[73]}, 32'h7F);
        chk("c1_out10", {24'h0, dm[74]}, 32'h5F);
        for (int i = 0; i < 64; i++) snap[i] = dm[64 + i];

        // Zero seed behaves like seed 1
        load(0, 8'd10, 8'h5C, 8'h00);
        push_exp(10, 7'h5C, 7'h00, 1'b0);
        run(1'b0, 1'b0, cyc);
        nd = 0;
        for (int i = 0; i < 64; i++) if (dm[64 + i] !== snap[i]) nd++;
        chk("seed0_matches_seed1", nd, 0);

        // All-space message: ciphertext equals the keystream
        load(1, 8'd26, 8'h60, 8'h35);
        push_exp(26, 7'h60, 7'h35, 1'b0);
        run(1'b0, 1'b0, cyc);
        chk("space_out0_seed", {24'h0, dm[64]}, 32'h35);

        // pre 0 with upper-bit config bits set, tail padding, req glitch while busy
        load(2, 8'hC0, 8'hF1, 8'hFF);
        push_exp(0, 7'h71, 7'h7F, 1'b0);
        run(1'b0, 1'b1, cyc);
        repeat (5) @(negedge clk);
        chk("done_hold_ack", {31'h0, if0.ack}, 1);
        if0.req = 1'b1;
        @(posedge clk);
        #1 chk("done_ack_drop", {31'h0, if0.ack}, 0);

        // Parity variant on case 1
        load(0, 8'd10, 8'h5C, 8'h01);
        push_exp(10, 7'h5C, 7'h01, 1'b1);
        run(1'b1, 1'b0, cyc);
        chk("par_out0",  {24'h0, dm[64]}, 32'h01);
        chk("par_out3",  {24'h0, dm[67]}, 32'h89);
        chk("par_out10", {24'h0, dm[74]}, 32'hDF);

        // Abort with init during the WR of byte 20
        load(0, 8'd10, 8'h5C, 8'h01);
        push_exp(10, 7'h5C, 7'h01, 1'b0);
        @(negedge clk);
        sel = 1'b0;
        if0.req = 1'b1;
        @(negedge clk);
        if0.req = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 300 && !found; c++) begin
            @(negedge clk);
            if (w_wr_en === 1'b1 && w_addr == 8'd84) found = 1'b1;
        end
        chk("abort_reached_byte20", {31'h0, found}, 1);
        init = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_ack",   {31'h0, if0.ack}, 0);
        chk("abort_wr_en", {31'h0, if0.mem_wr_en}, 0);
        @(negedge clk);
        init = 1'b0;
        chk("abort_pending", q_addr.size(), 43);
        q_addr.delete();
        q_data.delete();
        repeat (10) @(negedge clk);
        chk("abort_ack_idle", {31'h0, if0.ack}, 0);
        nd = 0;
        for (int j = 85; j < 128; j++) if (dm[j] !== 8'hEE) nd++;
        chk("abort_no_late_writes", nd, 0);

        // Rerun after abort produces the full result
        push_exp(10, 7'h5C, 7'h01, 1'b0);
        run(1'b0, 1'b0, cyc);
        nd = 0;
        for (int i = 0; i < 64; i++) if (dm[64 + i] !== snap[i]) nd++;
        chk("rerun_full_result", nd, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
